ext_irq_controller: RTL and testbench

- External interrupt source for processor_arm; drives the processor's ExtIRQ input and consumes its acknowledge.
- Synchronises N_SRC asynchronous device request lines and detects rising edges.
- Latches requests as pending and arbitrates by fixed priority.
- Presents one request at a time on ExtIRQ with a source ID; holds it until the processor acknowledges entry to the exception handler.

---
 rtl/ext_irq_controller.sv | 149 ++++++++++++++
 tb/tb_ext_irq_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_controller.sv
`timescale 1ns / 1ps
// ext_irq_controller
// External interrupt source for the processor's ExtIRQ input. Synchronises
// asynchronous device request lines, detects rising edges, latches them as
// pending, and presents the lowest-index eligible source to the processor,
// holding it until the processor acknowledges entry to the handler.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   irq_src   in   asynchronous request lines, rising edge = event
//   irq_mask  in   1 = source masked (still latches pending, not presented)
//   ExtIAck   in   one-cycle ack pulse when the exception is taken
//   lost_clr  in   synchronous clear of the lost flags
//   ExtIRQ    out  registered interrupt request
//   irq_id    out  index of the presented source, valid while ExtIRQ=1
//   pending   out  registered pending flags
//   lost      out  sticky per-source dropped-event flags
module ext_irq_controller #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             ExtIAck,
    input  logic             lost_clr,
    output logic             ExtIRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] lost
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAssert = 2'd1,
        StGap    = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_d;

    logic [N_SRC-1:0] r_s1;
    logic [N_SRC-1:0] r_s2;
    logic [N_SRC-1:0] r_s3;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_lost;
    logic             r_irq;
    logic [ID_W-1:0]  r_id;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_pending_d;
    logic [N_SRC-1:0] w_lost_d;
    logic [ID_W-1:0]  w_winner;
    logic             w_irq_d;
    logic [ID_W-1:0]  w_id_d;

    assign w_rise     = r_s2 & ~r_s3;
    assign w_eligible = r_pending & ~irq_mask;

    // Clear only the presented source, and only while a request is outstanding;
    // acks in IDLE or GAP are ignored.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i] = (r_state == StAssert) && ExtIAck && (r_id == ID_W'(i));
        end
    end

    // Set wins over clear, so an event coinciding with its own ack is kept.
    assign w_pending_d = (r_pending & ~w_clr) | w_rise;

    // A new loss wins over lost_clr.
    always_comb begin
        w_lost_d = lost_clr ? '0 : r_lost;
        w_lost_d = w_lost_d | (w_rise & r_pending & ~w_clr);
    end

    // Fixed priority: lowest index wins, so scan from the top down.
    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_irq_d   = r_irq;
        w_id_d    = r_id;
        unique case (r_state)
            StIdle: begin
                if (|w_eligible) begin
                    w_state_d = StAssert;
                    w_irq_d   = 1'b1;
                    w_id_d    = w_winner;
                end
            end
            StAssert: begin
                // Held without retraction or preemption until acknowledged.
                if (ExtIAck) begin
                    w_state_d = StGap;
                    w_irq_d   = 1'b0;
                end
            end
            StGap: begin
                w_state_d = StIdle;
                w_irq_d   = 1'b0;
            end
            default: begin
                w_state_d = StIdle;
                w_irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_pending <= '0;
            r_lost    <= '0;
            r_state   <= StIdle;
            r_irq     <= 1'b0;
            r_id      <= '0;
        end else begin
            r_s1      <= irq_src;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_pending <= w_pending_d;
            r_lost    <= w_lost_d;
            r_state   <= w_state_d;
            r_irq     <= w_irq_d;
            r_id      <= w_id_d;
        end
    end

    assign ExtIRQ  = r_irq;
    assign irq_id  = r_id;
    assign pending = r_pending;
    assign lost    = r_lost;

endmodule

// File: tb/tb_ext_irq_controller.sv
`timescale 1ns / 1ps
// Directed bench for ext_irq_controller (N_SRC=4, ID_W=2). Inputs change 1 ns
// after a rising edge, outputs are sampled at the same point.
module tb_ext_irq_controller;

    logic       CLOCK_50;
    logic       reset;
    logic [3:0] irq_src;
    logic [3:0] irq_mask;
    logic       ExtIAck;
    logic       lost_clr;
    logic       ExtIRQ;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] lost;

    int n_tests = 0;
    int n_fail  = 0;
    int n_high;

    ext_irq_controller #(
        .N_SRC(4),
        .ID_W (2)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .irq_src (irq_src),
        .irq_mask(irq_mask),
        .ExtIAck (ExtIAck),
        .lost_clr(lost_clr),
        .ExtIRQ  (ExtIRQ),
        .irq_id  (irq_id),
        .pending (pending),
        .lost    (lost)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic ack_pulse();
        ExtIAck = 1'b1;
        tick(1);
        ExtIAck = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        irq_src  = '0;
        irq_mask = '0;
        ExtIAck  = 1'b0;
        lost_clr = 1'b0;
        tick(2);
        check("rst_irq", 32'(ExtIRQ), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        reset = 1'b0;
        tick(1);

        // Reset mid-request
        irq_src = 4'b0010;
        tick(4);
        check("midrst_pre_irq", 32'(ExtIRQ), 32'd1);
        check("midrst_pre_id", 32'(irq_id), 32'd1);
        #3;
        reset   = 1'b1;
        irq_src = '0;
        #1;
        check("midrst_async_irq", 32'(ExtIRQ), 32'd0);
        check("midrst_async_pending", 32'(pending), 32'd0);
        check("midrst_async_lost", 32'(lost), 32'd0);
        tick(1);
        reset = 1'b0;
        ack_pulse();
        check("midrst_ack_irq", 32'(ExtIRQ), 32'd0);
        check("midrst_ack_pending", 32'(pending), 32'd0);
        tick(3);

        // Single event: source 2 rises before edge 0 and is held
        irq_src = 4'b0100;
        tick(2);
        check("single_e1_pending", 32'(pending), 32'd0);
        tick(1);
        check("single_e2_pending", 32'(pending), 32'b0100);
        check("single_e2_irq", 32'(ExtIRQ), 32'd0);
        tick(1);
        check("single_e3_irq", 32'(ExtIRQ), 32'd1);
        check("single_e3_id", 32'(irq_id), 32'd2);
        tick(2);
        ack_pulse();
        check("single_ack_irq", 32'(ExtIRQ), 32'd0);
        check("single_ack_pending", 32'(pending), 32'd0);
        n_high = 0;
        for (int i = 0; i < 10; i++) begin
            if (ExtIRQ) n_high++;
            tick(1);
        end
        check("single_level_one_event", 32'(n_high), 32'd0);
        check("single_level_pending", 32'(pending), 32'd0);
        irq_src = '0;
        tick(4);

        // Priority: sources 3 and 1 together
        irq_src = 4'b1010;
        tick(3);
        check("prio_pending", 32'(pending), 32'b1010);
        tick(1);
        check("prio_first_irq", 32'(ExtIRQ), 32'd1);
        check("prio_first_id", 32'(irq_id), 32'd1);
        ack_pulse();
        check("prio_gap1_irq", 32'(ExtIRQ), 32'd0);
        check("prio_after_ack_pending", 32'(pending), 32'b1000);
        tick(1);
        check("prio_gap2_irq", 32'(ExtIRQ), 32'd0);
        tick(1);
        check("prio_second_irq", 32'(ExtIRQ), 32'd1);
        check("prio_second_id", 32'(irq_id), 32'd3);
        ack_pulse();
        check("prio_done_pending", 32'(pending), 32'd0);
        irq_src = '0;
        tick(4);

        // Masking
        irq_mask = 4'b0001;
        irq_src  = 4'b0001;
        tick(3);
        check("mask_pending", 32'(pending), 32'b0001);
        n_high = 0;
        for (int i = 0; i < 20; i++) begin
            if (ExtIRQ) n_high++;
            tick(1);
        end
        check("mask_irq_held_low", 32'(n_high), 32'd0);
        irq_mask = 4'b0000;
        tick(1);
        check("unmask_irq", 32'(ExtIRQ), 32'd1);
        check("unmask_id", 32'(irq_id), 32'd0);
        ack_pulse();
        tick(2);
        irq_src = '0;
        tick(4);

        // Lost: second edge on source 2 while pending and unacknowledged
        irq_src = 4'b0100;
        tick(4);
        check("lost_pre_irq", 32'(ExtIRQ), 32'd1);
        irq_src = '0;
        tick(3);
        irq_src = 4'b0100;
        tick(3);
        check("lost_set", 32'(lost), 32'b0100);
        check("lost_pending", 32'(pending), 32'b0100);
        check("lost_irq_held", 32'(ExtIRQ), 32'd1);
        check("lost_id_held", 32'(irq_id), 32'd2);
        lost_clr = 1'b1;
        tick(1);
        lost_clr = 1'b0;
        check("lost_clr", 32'(lost), 32'd0);

        // Coincident set/clear: new rise on 2 lands on the ack edge
        irq_src = '0;
        tick(3);
        irq_src = 4'b0100;
        tick(2);
        ack_pulse();
        check("coinc_irq", 32'(ExtIRQ), 32'd0);
        check("coinc_pending", 32'(pending), 32'b0100);
        check("coinc_lost", 32'(lost), 32'd0);
        // Spurious ack in GAP, with the presented source still pending
        ack_pulse();
        check("gapack_irq", 32'(ExtIRQ), 32'd0);
        check("gapack_pending", 32'(pending), 32'b0100);
        check("gapack_lost", 32'(lost), 32'd0);
        tick(1);
        check("coinc_repres_irq", 32'(ExtIRQ), 32'd1);
        check("coinc_repres_id", 32'(irq_id), 32'd2);
        ack_pulse();
        check("coinc_done_pending", 32'(pending), 32'd0);
        irq_src = '0;
        tick(4);

        // Spurious ack in IDLE with nothing pending
        ack_pulse();
        check("idleack0_irq", 32'(ExtIRQ), 32'd0);
        check("idleack0_pending", 32'(pending), 32'd0);
        tick(2);
        check("idleack0_irq_later", 32'(ExtIRQ), 32'd0);

        // Spurious ack in IDLE with masked source 2 pending (irq_id still 2)
        irq_mask = 4'b0100;
        irq_src  = 4'b0100;
        tick(3);
        check("idleack_pre_pending", 32'(pending), 32'b0100);
        ack_pulse();
        check("idleack_pending", 32'(pending), 32'b0100);
        check("idleack_lost", 32'(lost), 32'd0);
        check("idleack_irq", 32'(ExtIRQ), 32'd0);
        irq_mask = 4'b0000;
        tick(1);
        check("idleack_unmask_irq", 32'(ExtIRQ), 32'd1);
        check("idleack_unmask_id", 32'(irq_id), 32'd2);
        ack_pulse();
        check("idleack_final_pending", 32'(pending), 32'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
